// File: rtl/cpu_0_jtag_mon_pkg.sv
// cpu_0_jtag_mon_pkg
// Shared definitions for the debug-monitor memory controller: FSM state
// encoding, bit positions of the fields carried in the captured jdo word,
// and the data word that replaces a read aborted by the transfer timeout.
package cpu_0_jtag_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } mon_state_e;

  // Field positions inside jdo
  localparam int ADDR_LSB    = 2;
  localparam int CLR_ERR_BIT = 34;
  localparam int RD_BIT      = 35;
  localparam int WDATA_LSB   = 3;
  localparam int DATA_W      = 32;

  // Substituted for the read data when a read times out
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/cpu_0_jtag_mon_ctrl.sv
// cpu_0_jtag_mon_ctrl
// System-clock side of the JTAG debug monitor. Turns the ocimem strobes and
// the captured jdo word into single-word reads and writes on a wait-stated
// memory master port, and reports the result back through MonDReg,
// monitor_ready and the sticky monitor_error flag.
// Optional build macro CPU_0_MON_TIMEOUT_EN adds a stall counter that aborts
// a transfer stuck on waitrequest for TIMEOUT_CYC cycles.
module cpu_0_jtag_mon_ctrl
  import cpu_0_jtag_mon_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  mon_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic              ready_q;
  logic              error_q;
  logic              anyStrobe;
  logic [ADDR_W-1:0] addrNext;

`ifdef CPU_0_MON_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             unused_ok;
  assign unused_ok = ^{jdo[37:36], jdo[1:0]};
`else
  logic             unused_ok;
  assign unused_ok = ^{jdo[37:36], jdo[1:0], 32'(TIMEOUT_CYC)};
`endif

  assign anyStrobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign addrNext  = addr_q + ADDR_W'(1);

  // Single registered FSM: strobe decode in IDLE, completion/abort and overrun detection while busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
`ifdef CPU_0_MON_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef CPU_0_MON_TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (take_action_ocimem_b) begin
            data_q  <= jdo[WDATA_LSB +: DATA_W];
            wdata_q <= jdo[WDATA_LSB +: DATA_W];
            wr_q    <= 1'b1;
            ready_q <= 1'b0;
            state_q <= WR;
          end else if (take_action_ocimem_a) begin
            addr_q <= jdo[ADDR_LSB +: ADDR_W];
            if (jdo[CLR_ERR_BIT]) begin
              error_q <= 1'b0;
            end
            if (jdo[RD_BIT]) begin
              rd_q    <= 1'b1;
              ready_q <= 1'b0;
              state_q <= RD;
            end
          end else if (take_no_action_ocimem_a) begin
            rd_q    <= 1'b1;
            ready_q <= 1'b0;
            state_q <= RD;
          end
        end
        RD, WR: begin
          if (anyStrobe) begin
            error_q <= 1'b1;
          end
          if (!avm_waitrequest) begin
            if (state_q == RD) begin
              data_q <= avm_readdata;
            end
            addr_q  <= addrNext;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
`ifdef CPU_0_MON_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            if (state_q == RD) begin
              data_q <= TIMEOUT_DATA;
            end
            error_q <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        default: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;
  assign MonAReg       = addr_q;
  assign MonDReg       = data_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_cpu_0_jtag_mon_ctrl.sv
// tb_cpu_0_jtag_mon_ctrl
// Directed and randomized transfers against a transaction-level model of the
// monitor: address, data and error flag are tracked as plain integers and
// updated per host command. The slave returns data that is a fixed function
// of the requested address. Define CPU_0_MON_TIMEOUT_EN to also exercise the
// transfer timeout.
module tb_cpu_0_jtag_mon_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [8:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [8:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int checks = 0;
  int errors = 0;

  // Reference state of the monitor as seen by the host
  int          mA;
  logic [31:0] mD;
  logic        mErr;

  cpu_0_jtag_mon_ctrl #(.ADDR_W(9), .TIMEOUT_CYC(255)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest),
    .MonAReg                 (MonAReg),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdFunc(input int a);
    if (a == 32'h010) return 32'h1234_5678;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign avm_readdata = rdFunc(int'(avm_address));

  function automatic logic [37:0] mkA(input int addr, input logic clr, input logic rd);
    logic [37:0] j;
    j = '0;
    j[10:2] = addr[8:0];
    j[34]   = clr;
    j[35]   = rd;
    return j;
  endfunction

  function automatic logic [37:0] mkB(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // kind: 0=ocimem_b, 1=ocimem_a, 2=no_action_a, 3=all three at once
  task automatic applyStimulus(input int kind, input logic [37:0] j);
    jdo                     = j;
    take_action_ocimem_b    = (kind == 0 || kind == 3);
    take_action_ocimem_a    = (kind == 1 || kind == 3);
    take_no_action_ocimem_a = (kind == 2 || kind == 3);
  endtask

  task automatic clearStimulus();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, 32'(monitor_ready), 32'd1);
    checkOutput({tag, "_req"}, {30'd0, avm_read, avm_write}, 32'd0);
    checkOutput({tag, "_addr"}, 32'(MonAReg), 32'(mA));
    checkOutput({tag, "_data"}, MonDReg, mD);
    checkOutput({tag, "_err"}, 32'(monitor_error), 32'(mErr));
  endtask

  // One host command with the given number of stalled request cycles
  task automatic runXfer(input string tag, input int kind, input logic [37:0] j,
                         input int stalls, input logic overrun);
    logic        isRd, isWr;
    int          reqAddr;
    logic [31:0] wData;
    isRd = 1'b0;
    isWr = 1'b0;
    wData = j[34:3];
    if (kind == 0 || kind == 3) begin
      isWr = 1'b1;
    end else if (kind == 1) begin
      mA = int'(j[10:2]);
      if (j[34]) mErr = 1'b0;
      isRd = j[35];
    end else begin
      isRd = 1'b1;
    end
    reqAddr = mA;
    applyStimulus(kind, j);
    stepClk();
    clearStimulus();
    if (!isRd && !isWr) begin
      checkIdle(tag);
      return;
    end
    for (int c = 0; c <= stalls; c++) begin
      avm_waitrequest = (c < stalls);
      if (overrun && c == 0) begin
        take_no_action_ocimem_a = 1'b1;
        mErr = 1'b1;
      end
      checkOutput({tag, "_busy"}, {29'd0, avm_read, avm_write, monitor_ready}, {29'd0, isRd, isWr, 1'b0});
      checkOutput({tag, "_reqaddr"}, 32'(avm_address), 32'(reqAddr));
      if (isWr) checkOutput({tag, "_wdata"}, avm_writedata, wData);
      stepClk();
      clearStimulus();
    end
    avm_waitrequest = 1'b0;
    mD = isRd ? rdFunc(reqAddr) : wData;
    mA = (mA + 1) % 512;
    checkIdle(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    reset_n = 1'b0;
    jdo = '0;
    clearStimulus();
    avm_waitrequest = 1'b0;
    mA = 0;
    mD = 32'd0;
    mErr = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    stepClk();
    checkIdle("reset");
    checkOutput("reset_wdata", avm_writedata, 32'd0);

    // Load address and read, no stall: ready two cycles after the strobe
    runXfer("rd010", 1, mkA(32'h010, 1'b0, 1'b1), 0, 1'b0);
    checkOutput("rd010_val", MonDReg, 32'h1234_5678);

    // Write with three stalled cycles
    runXfer("wrcafe", 0, mkB(32'hCAFE_F00D), 3, 1'b0);

    // Address wrap on read at 0x1FF
    runXfer("ld1ff", 1, mkA(32'h1FF, 1'b0, 1'b0), 0, 1'b0);
    runXfer("wrap", 2, '0, 1, 1'b0);
    checkOutput("wrap_zero", 32'(MonAReg), 32'd0);

    // Overrun during stalled read, then clear via ocimem_a
    runXfer("ovr", 2, '0, 2, 1'b1);
    checkOutput("ovr_err", 32'(monitor_error), 32'd1);
    runXfer("clr", 1, mkA(32'h020, 1'b1, 1'b0), 0, 1'b0);
    checkOutput("clr_err", 32'(monitor_error), 32'd0);

    // Simultaneous strobes: write wins, address load dropped
    runXfer("prio", 3, mkB(32'h8765_4321), 1, 1'b0);

    // Randomized command sequence
    for (int i = 0; i < 24; i++) begin
      int kind;
      int st;
      logic [37:0] j;
      kind = $urandom_range(0, 2);
      st = $urandom_range(0, 3);
      if (kind == 0) j = mkB($urandom);
      else if (kind == 1) j = mkA($urandom_range(0, 511), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else j = '0;
      runXfer("rand", kind, j, st, 1'($urandom_range(0, 3) == 0 && st > 0));
    end

    // Reset in the middle of a stalled read
    avm_waitrequest = 1'b1;
    applyStimulus(2, '0);
    stepClk();
    clearStimulus();
    repeat (3) stepClk();
    checkOutput("rstmid_busy", 32'(avm_read), 32'd1);
    reset_n = 1'b0;
    #1;
    mA = 0;
    mD = 32'd0;
    mErr = 1'b0;
    checkIdle("rstmid");
    stepClk();
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    stepClk();
    runXfer("postrst", 1, mkA(32'h0AB, 1'b0, 1'b1), 0, 1'b0);

`ifdef CPU_0_MON_TIMEOUT_EN
    // Read stuck on waitrequest aborts after TIMEOUT_CYC stalled cycles
    mA = 32'h055;
    avm_waitrequest = 1'b1;
    applyStimulus(1, mkA(32'h055, 1'b0, 1'b1));
    stepClk();
    clearStimulus();
    cnt = 0;
    while (avm_read === 1'b1 && cnt < 400) begin
      cnt++;
      stepClk();
    end
    avm_waitrequest = 1'b0;
    checkOutput("tmo_cycles", 32'(cnt), 32'd255);
    mErr = 1'b1;
    mD = 32'hDEAD_BEEF;
    checkIdle("tmo");
`else
    cnt = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
